// File: rtl/mii_frame_gen.sv
// 64-bit MII-style TX framer: IDLE, START, payload, EOF and inter-packet gap, length-policed.
// Optional MII_FRAME_GEN_PAD_EN zero-pads short frames instead of flagging them on o_trunc.
module mii_frame_gen #(
    parameter int unsigned DATA_WIDTH         = 64,
    parameter int unsigned CTRL_WIDTH         = 8,
    parameter logic [7:0]  IDLE_CODE          = 8'h07,
    parameter logic [7:0]  START_CODE         = 8'hFB,
    parameter logic [7:0]  EOF_CODE           = 8'hFD,
    parameter logic [7:0]  ERROR_CODE         = 8'hFE,
    parameter int unsigned IPG_CYCLES         = 2,
    parameter int unsigned MIN_PAYLOAD_CYCLES = 5,
    parameter int unsigned MAX_PAYLOAD_CYCLES = 17
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic [CTRL_WIDTH-1:0] o_tx_ctrl,
    output logic                  o_trunc,
    output logic                  o_underrun
);
    localparam logic [4:0] MinCnt  = 5'(MIN_PAYLOAD_CYCLES);
    localparam logic [4:0] MaxCnt  = 5'(MAX_PAYLOAD_CYCLES);
    localparam logic [7:0] IpgLast = 8'(IPG_CYCLES);

    localparam logic [DATA_WIDTH-1:0] IdleWord  = {CTRL_WIDTH{IDLE_CODE}};
    localparam logic [DATA_WIDTH-1:0] StartWord = {8'hD5, {(CTRL_WIDTH-2){8'h55}}, START_CODE};
    localparam logic [DATA_WIDTH-1:0] EofWord   = {EOF_CODE, {(CTRL_WIDTH-1){IDLE_CODE}}};
    localparam logic [DATA_WIDTH-1:0] ErrWord   = {CTRL_WIDTH{ERROR_CODE}};
    localparam logic [CTRL_WIDTH-1:0] CtrlAll   = '1;
    localparam logic [CTRL_WIDTH-1:0] CtrlStart = CTRL_WIDTH'(1);

`ifdef MII_FRAME_GEN_PAD_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StPad, StErr, StEof, StIpg} state_t;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StErr, StEof, StIpg} state_t;
`endif

    state_t     state_q;
    logic [4:0] cnt_q;
    logic [7:0] ipg_q;
    logic       drain_q;
    logic       trunc_pend_q;
    logic [4:0] cnt_plus;
    logic [4:0] cnt_sat;

    assign cnt_plus = cnt_q + 5'd1;
    assign cnt_sat  = (cnt_q >= MaxCnt) ? MaxCnt : cnt_plus;

    always_comb begin
        o_ready = drain_q;
        if (state_q == StStart || state_q == StData) o_ready = 1'b1;
    end

    // StEof holds the final payload word on the line; the EOF word goes out on leaving it.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= StIdle;
            o_tx_data    <= IdleWord;
            o_tx_ctrl    <= CtrlAll;
            o_trunc      <= 1'b0;
            o_underrun   <= 1'b0;
            cnt_q        <= '0;
            ipg_q        <= '0;
            drain_q      <= 1'b0;
            trunc_pend_q <= 1'b0;
        end else begin
            o_trunc    <= 1'b0;
            o_underrun <= 1'b0;
            if (drain_q && i_valid && i_last) drain_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    o_tx_data <= IdleWord;
                    o_tx_ctrl <= CtrlAll;
                    if (i_valid && !drain_q) begin
                        state_q   <= StStart;
                        o_tx_data <= StartWord;
                        o_tx_ctrl <= CtrlStart;
                        cnt_q     <= '0;
                    end
                end
                StStart, StData: begin
                    if (i_valid) begin
                        o_tx_data <= i_data;
                        o_tx_ctrl <= '0;
                        cnt_q     <= cnt_sat;
                        state_q   <= StData;
                        if (i_last) begin
                            state_q <= StEof;
                            if (cnt_plus < MinCnt) begin
`ifdef MII_FRAME_GEN_PAD_EN
                                state_q <= StPad;
`else
                                trunc_pend_q <= 1'b1;
`endif
                            end
                        end else if (cnt_plus >= MaxCnt) begin
                            state_q      <= StEof;
                            trunc_pend_q <= 1'b1;
                            drain_q      <= 1'b1;
                        end
                    end else begin
                        state_q    <= StErr;
                        o_tx_data  <= ErrWord;
                        o_tx_ctrl  <= CtrlAll;
                        o_underrun <= 1'b1;
                        drain_q    <= 1'b1;
                    end
                end
`ifdef MII_FRAME_GEN_PAD_EN
                StPad: begin
                    o_tx_data <= '0;
                    o_tx_ctrl <= '0;
                    cnt_q     <= cnt_sat;
                    if (cnt_plus >= MinCnt) state_q <= StEof;
                end
`endif
                StErr, StEof: begin
                    o_tx_data    <= EofWord;
                    o_tx_ctrl    <= CtrlAll;
                    o_trunc      <= trunc_pend_q;
                    trunc_pend_q <= 1'b0;
                    ipg_q        <= '0;
                    state_q      <= StIpg;
                end
                StIpg: begin
                    o_tx_data <= IdleWord;
                    o_tx_ctrl <= CtrlAll;
                    ipg_q     <= ipg_q + 8'd1;
                    // The gap's last cycle doubles as the IDLE decision, so no extra idle word.
                    if (ipg_q >= IpgLast) begin
                        state_q <= StIdle;
                        if (i_valid && !drain_q) begin
                            state_q   <= StStart;
                            o_tx_data <= StartWord;
                            o_tx_ctrl <= CtrlStart;
                            cnt_q     <= '0;
                        end
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    o_tx_data <= IdleWord;
                    o_tx_ctrl <= CtrlAll;
                end
            endcase
        end
    end

endmodule
